mbisr_chain_driver: RTL and testbench

- Controller at the driving end of an MBISR repair register chain. It accepts parallel repair-word commands on a valid/ready interface and serializes each word onto the chain's SI with SE asserted.
- While shifting, it samples the chain's retimed SO and deserializes the returned bits into a response word.
- It also issues single-cycle capture operations (SE low) so chain registers load their parallel D inputs.
- It sits between the fuse/repair-analysis controller and the head/tail of the per-memory MBISR register chain.

---
 rtl/mbisr_chain_driver.sv | 161 ++++++++++++++++
 tb/tb_mbisr_chain_driver.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbisr_chain_driver.sv
// Driving-end controller for an MBISR repair register chain: serializes SHIFT words
// onto SI (LSB first), deserializes SO into a response, and issues single-cycle captures.
module mbisr_chain_driver #(
    parameter  int WORD_W = 22,
    localparam int CNT_W  = $clog2(WORD_W)
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WORD_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              chain_si,
    output logic              chain_se,
    output logic              chain_clk_en,
    input  logic              chain_so
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_SHIFT = 2'b00;
    localparam logic [1:0] OP_CAPT  = 2'b01;

    state_t state_reg, state_next;

    // Bit 0 of the word goes straight to chain_si on accept, so only the upper bits are held.
    logic [WORD_W-2:0] tx_sh_reg, tx_sh_next;
    logic [WORD_W-2:0] rx_sh_reg, rx_sh_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WORD_W-1:0] rx_word;
    logic [WORD_W-1:0] rsp_data_next;
    logic              cmd_ready_next, rsp_valid_next, rsp_err_next;
    logic              chain_si_next, chain_se_next, chain_clk_en_next;
    logic              accept, rsp_done, shift_last;

    assign accept     = cmd_valid && cmd_ready;
    assign rsp_done   = rsp_valid && rsp_ready;
    assign shift_last = (cnt_reg == CNT_W'(WORD_W - 1));
    assign rx_word    = {chain_so, rx_sh_reg};

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_reg    <= IDLE;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            cnt_reg      <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            chain_si     <= 1'b0;
            chain_se     <= 1'b0;
            chain_clk_en <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_sh_reg    <= tx_sh_next;
            rx_sh_reg    <= rx_sh_next;
            cnt_reg      <= cnt_next;
            cmd_ready    <= cmd_ready_next;
            rsp_valid    <= rsp_valid_next;
            rsp_data     <= rsp_data_next;
            rsp_err      <= rsp_err_next;
            chain_si     <= chain_si_next;
            chain_se     <= chain_se_next;
            chain_clk_en <= chain_clk_en_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_SHIFT: state_next = SHIFT;
                        OP_CAPT:  state_next = CAPT;
                        default:  state_next = RESP;
                    endcase
                end
            end
            SHIFT:   if (shift_last) state_next = RESP;
            CAPT:    state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_sh_next        = tx_sh_reg;
        rx_sh_next        = rx_sh_reg;
        cnt_next          = cnt_reg;
        cmd_ready_next    = 1'b0;
        rsp_valid_next    = rsp_valid;
        rsp_data_next     = rsp_data;
        rsp_err_next      = rsp_err;
        chain_si_next     = 1'b0;
        chain_se_next     = 1'b0;
        chain_clk_en_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready_next = !accept;
                if (accept) begin
                    case (cmd_op)
                        OP_SHIFT: begin
                            tx_sh_next        = cmd_wdata[WORD_W-1:1];
                            cnt_next          = '0;
                            chain_si_next     = cmd_wdata[0];
                            chain_se_next     = 1'b1;
                            chain_clk_en_next = 1'b1;
                        end
                        OP_CAPT: begin
                            chain_clk_en_next = 1'b1;
                        end
                        default: begin
                            rsp_valid_next = 1'b1;
                            rsp_data_next  = '0;
                            rsp_err_next   = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                tx_sh_next = tx_sh_reg >> 1;
                rx_sh_next = rx_word[WORD_W-1:1];
                if (shift_last) begin
                    cnt_next       = '0;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = rx_word;
                    rsp_err_next   = 1'b0;
                end else begin
                    cnt_next          = cnt_reg + CNT_W'(1);
                    chain_si_next     = tx_sh_reg[0];
                    chain_se_next     = 1'b1;
                    chain_clk_en_next = 1'b1;
                end
            end
            CAPT: begin
                rsp_valid_next = 1'b1;
                rsp_data_next  = '0;
                rsp_err_next   = 1'b0;
            end
            RESP: begin
                if (rsp_done) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mbisr_chain_driver.sv
// Bench for mbisr_chain_driver: behavioural chain of up to three registers with retimed SO,
// scoreboard of expected responses, one task per scenario.
module tb_mbisr_chain_driver;

    localparam int W = 22;

    logic         CLK = 1'b0;
    logic         RSTB;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         chain_si;
    logic         chain_se;
    logic         chain_clk_en;
    logic         chain_so;

    mbisr_chain_driver #(.WORD_W(W)) dut (
        .CLK          (CLK),
        .RSTB         (RSTB),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .chain_si     (chain_si),
        .chain_se     (chain_se),
        .chain_clk_en (chain_clk_en),
        .chain_so     (chain_so)
    );

    always #5 CLK = ~CLK;

    // Chain model: register 0 is the head (fed by SI), SO comes from register nseg-1.
    logic [W-1:0] chain [3];
    logic [W-1:0] load_val [3];
    logic         load_en = 1'b0;
    logic [W-1:0] cap_d = '0;
    int           nseg = 1;
    int           en_cnt = 0;
    int           capt_cnt = 0;

    always @(posedge CLK) begin
        if (load_en) begin
            for (int r = 0; r < 3; r++) chain[r] <= load_val[r];
        end else if (chain_clk_en) begin
            if (chain_se) begin
                chain[0] <= {chain_si, chain[0][W-1:1]};
                for (int r = 1; r < 3; r++) chain[r] <= {chain[r-1][0], chain[r][W-1:1]};
            end else begin
                for (int r = 0; r < 3; r++) chain[r] <= cap_d;
            end
        end
    end

    always @(posedge CLK) begin
        if (chain_clk_en) en_cnt <= en_cnt + 1;
        if (chain_clk_en && !chain_se) capt_cnt <= capt_cnt + 1;
    end

    always @(negedge CLK) chain_so <= chain[nseg-1][0];

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input int n, input logic [W-1:0] v0, input logic [W-1:0] v1,
                           input logic [W-1:0] v2);
        nseg = n;
        load_val[0] = v0;
        load_val[1] = v1;
        load_val[2] = v2;
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        tick();
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        ok = cmd_ready;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] wd);
        bit ok;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_ready: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = '0;
    endtask

    // Returns the cycle index (accept edge = edge 0) at which rsp_valid is first seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        RSTB = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_wdata = 22'h3FFFFF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, chain_si, chain_se, chain_clk_en} !== 6'b0 ||
            rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b err=%0b si=%0b se=%0b en=%0b data=%h required all 0",
                     cmd_ready, rsp_valid, rsp_err, chain_si, chain_se, chain_clk_en, rsp_data);
        end
        cmd_valid = 1'b0;
        cmd_wdata = '0;
        RSTB = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || chain_se !== 1'b0 ||
                chain_clk_en !== 1'b0 || chain_si !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: ready=%0b valid=%0b se=%0b en=%0b si=%0b required 1,0,0,0,0",
                         i, cmd_ready, rsp_valid, chain_se, chain_clk_en, chain_si);
            end
            tick();
        end
        rsp_ready = 1'b0;
        $display("reset/idle: done");
    endtask

    task automatic test_shift_single();
        int   cyc;
        int   en0;
        rsp_t e;
        preload(1, 22'h0ABCDE, '0, '0);
        en0 = en_cnt;
        exp_q.push_back('{data: 22'h0ABCDE, err: 1'b0});
        send(2'b00, 22'h155AA3);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 23) begin
            errors++;
            $display("FAIL shift_latency: got %0d cycles required 23", cyc);
        end
        checks++;
        if (rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL shift_rsp: data=%h err=%0b required %h %0b", rsp_data, rsp_err, e.data, e.err);
        end
        checks++;
        if (chain[0] !== 22'h155AA3) begin
            errors++;
            $display("FAIL shift_chain: reg=%h required 155aa3", chain[0]);
        end
        checks++;
        if (en_cnt - en0 !== 22) begin
            errors++;
            $display("FAIL shift_clk_en: %0d cycles required 22", en_cnt - en0);
        end
        $display("shift single: latency=%0d rsp=%h chain=%h", cyc, rsp_data, chain[0]);
        finish_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL shift_handshake: valid=%0b ready=%0b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] words [6];
        int   cyc;
        rsp_t e;
        words[0] = 22'h000001;
        words[1] = 22'h000002;
        words[2] = 22'h3FFFFF;
        words[3] = '0;
        words[4] = '0;
        words[5] = '0;
        preload(3, '0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{data: (i < 3) ? 22'h0 : words[i-3], err: 1'b0});
            send(2'b00, words[i]);
            wait_valid(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc !== 23 || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++;
                $display("FAIL stream_rsp%0d: latency=%0d data=%h err=%0b required 23 %h %0b",
                         i, cyc, rsp_data, rsp_err, e.data, e.err);
            end
            $display("stream shift %0d: wdata=%h rsp=%h", i, words[i], rsp_data);
            if (i == 2) begin
                checks++;
                if (chain[0] !== 22'h3FFFFF || chain[1] !== 22'h000002 || chain[2] !== 22'h000001) begin
                    errors++;
                    $display("FAIL stream_chain: %h %h %h required 3fffff 000002 000001",
                             chain[0], chain[1], chain[2]);
                end
            end
            finish_rsp();
        end
    endtask

    task automatic test_capture();
        int   cyc;
        int   en0;
        int   c0;
        rsp_t e;
        preload(1, 22'h111111, '0, '0);
        cap_d = 22'h2AAAAA;
        en0 = en_cnt;
        c0 = capt_cnt;
        exp_q.push_back('{data: '0, err: 1'b0});
        send(2'b01, 22'h3C3C3C);
        wait_valid(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 2 || rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL capt_rsp: latency=%0d data=%h err=%0b required 2 %h %0b",
                     cyc, rsp_data, rsp_err, e.data, e.err);
        end
        checks++;
        if (chain[0] !== 22'h2AAAAA || en_cnt - en0 !== 1 || capt_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL capt_chain: reg=%h en=%0d capt=%0d required 2aaaaa 1 1",
                     chain[0], en_cnt - en0, capt_cnt - c0);
        end
        $display("capture: latency=%0d chain=%h", cyc, chain[0]);
        finish_rsp();
    endtask

    task automatic test_reserved();
        int   en0;
        rsp_t e;
        en0 = en_cnt;
        exp_q.push_back('{data: '0, err: 1'b1});
        send(2'b11, 22'h123456);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL reserved_rsp: valid=%0b data=%h err=%0b required 1 %h %0b",
                     rsp_valid, rsp_data, rsp_err, e.data, e.err);
        end
        checks++;
        if (en_cnt - en0 !== 0 || chain[0] !== 22'h2AAAAA) begin
            errors++;
            $display("FAIL reserved_chain: en=%0d reg=%h required 0 2aaaaa", en_cnt - en0, chain[0]);
        end
        $display("reserved op: err=%0b data=%h", rsp_err, rsp_data);
        finish_rsp();
    endtask

    task automatic test_back_pressure();
        int   cyc;
        int   en0;
        rsp_t e;
        exp_q.push_back('{data: 22'h2AAAAA, err: 1'b0});
        send(2'b00, 22'h0F0F0F);
        wait_valid(cyc);
        e = exp_q.pop_front();
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== e.data || rsp_err !== e.err) begin
                errors++;
                $display("FAIL stall_cycle%0d: valid=%0b ready=%0b data=%h err=%0b required 1 0 %h %0b",
                         i, rsp_valid, cmd_ready, rsp_data, rsp_err, e.data, e.err);
            end
            tick();
        end
        en0 = en_cnt;
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || chain_clk_en !== 1'b0 || en_cnt - en0 !== 0) begin
            errors++;
            $display("FAIL stall_release: valid=%0b ready=%0b en=%0b required 0 1 0",
                     rsp_valid, cmd_ready, chain_clk_en);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        $display("back pressure: rsp=%h held 5 cycles", e.data);
    endtask

    task automatic test_reset_mid_shift();
        bit seen = 1'b0;
        send(2'b00, 22'h0F0F0F);
        for (int i = 0; i < 9; i++) tick();
        RSTB = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, chain_si, chain_se, chain_clk_en} !== 6'b0 ||
            rsp_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%0b valid=%0b err=%0b si=%0b se=%0b en=%0b data=%h required all 0",
                     cmd_ready, rsp_valid, rsp_err, chain_si, chain_se, chain_clk_en, rsp_data);
        end
        tick();
        tick();
        RSTB = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid || chain_clk_en) seen = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_rsp: response or chain activity seen=%0b required 0", seen);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size());
        end
        $display("reset mid shift: aborted");
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_shift_single();
        test_stream();
        test_capture();
        test_reserved();
        test_back_pressure();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
